// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared types and encodings for the RV32 multi-cycle control
//               unit: controller state encoding, opcode/funct fields of the
//               supported instructions and ALU function selects.
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_FWAIT  = 4'd1,
        ST_INCB   = 4'd2,
        ST_INC    = 4'd3,
        ST_DECODE = 4'd4,
        ST_RS1R   = 4'd5,
        ST_RS1L   = 4'd6,
        ST_RS2R   = 4'd7,
        ST_RS2L   = 4'd8,
        ST_IMM    = 4'd9,
        ST_EXEC   = 4'd10,
        ST_ERROR  = 4'd11
    } state_t;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

endpackage
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_decode
// Description : Combinational instruction classifier. Recognises ADD, SUB
//               and ADDI and flags anything else, or any register index the
//               register file cannot hold, as illegal.
//   instr     in  32  latched instruction word
//   is_add    out 1   R-type ADD encoding
//   is_sub    out 1   R-type SUB encoding
//   is_addi   out 1   I-type ADDI encoding
//   illegal_q out 1   unsupported encoding or out-of-range register index
//   rs1/rs2/rd out 5  raw register index fields
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int RF_ADDR_W = 4
)(
    input  logic [31:0] instr,
    output logic        is_add,
    output logic        is_sub,
    output logic        is_addi,
    output logic        illegal_q,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd
);

    localparam int c_rf_depth = 2 ** RF_ADDR_W;

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_op_add3;
    logic       w_rtype;
    logic       w_rs1_bad;
    logic       w_rs2_bad;
    logic       w_rd_bad;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_funct7 = instr[31:25];
    assign rd       = instr[11:7];
    assign rs1      = instr[19:15];
    assign rs2      = instr[24:20];

    assign w_op_add3 = (w_opcode == OPC_OP) && (w_funct3 == F3_ADD);
    assign is_add    = w_op_add3 && (w_funct7 == F7_ADD);
    assign is_sub    = w_op_add3 && (w_funct7 == F7_SUB);
    assign is_addi   = (w_opcode == OPC_OPIMM) && (w_funct3 == F3_ADD);
    assign w_rtype   = is_add || is_sub;

    assign w_rs1_bad = (int'(rs1) >= c_rf_depth);
    assign w_rs2_bad = (int'(rs2) >= c_rf_depth);
    assign w_rd_bad  = (int'(rd)  >= c_rf_depth);

    // ADDI carries immediate bits where rs2 would sit, so rs2 only matters
    // for the register-register forms.
    assign illegal_q = !(w_rtype || is_addi) || w_rs1_bad || w_rd_bad ||
                       (w_rtype && w_rs2_bad);

endmodule
`default_nettype wire

// File: rtl/ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_fsm
// Description : Multi-cycle control unit for the single-bus RV32 datapath.
//               Sequences fetch, PC+4, operand load, execute and write-back
//               for ADD/SUB/ADDI, runs the instruction-fetch handshake with a
//               timeout, and counts retired instructions.
//   clk, rst            in   clock / synchronous active-high reset
//   instr               in   latched instruction word
//   alu_carry           in   ALU carry of the current operation
//   mem_ack             in   fetch data valid this cycle
//   mem_req             out  fetch request (address = bus = PC)
//   sel_alu_func        out  0 add, 1 sub
//   ir_en/a_en/b_en/pc_en           out  datapath register loads
//   *_bus_en            out  bus drivers, at most one active per cycle
//   rf_wen/rf_ren/rf_addr_sel       out  register-file access
//   carry_flag          out  carry of the last executed instruction
//   instret             out  retired-instruction count (wrapping)
//   illegal, mem_err    out  sticky error flags, cleared only by rst
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int RF_ADDR_W   = 4,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             alu_carry,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             sel_alu_func,
    output logic             ir_en,
    output logic             a_en,
    output logic             b_en,
    output logic             pc_en,
    output logic             immgen_bus_en,
    output logic             alu_bus_en,
    output logic             pc_bus_en,
    output logic             rf_bus_en,
    output logic             rd_bus_en,
    output logic             const4_bus_en,
    output logic             rf_wen,
    output logic             rf_ren,
    output logic [4:0]       rf_addr_sel,
    output logic             carry_flag,
    output logic [CNT_W-1:0] instret,
    output logic             illegal,
    output logic             mem_err
);

    localparam int                c_wait_w    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(MEM_TIMEOUT - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_wait_w-1:0] r_wait_cnt;
    logic                r_carry_flag;
    logic [CNT_W-1:0]    r_instret;
    logic                r_illegal;
    logic                r_mem_err;

    logic                w_is_add;
    logic                w_is_sub;
    logic                w_is_addi;
    logic                w_illegal_q;
    logic [4:0]          w_rs1;
    logic [4:0]          w_rs2;
    logic [4:0]          w_rd;
    logic                w_timeout;

    ctrl_decode #(
        .RF_ADDR_W (RF_ADDR_W)
    ) u_decode (
        .instr     (instr),
        .is_add    (w_is_add),
        .is_sub    (w_is_sub),
        .is_addi   (w_is_addi),
        .illegal_q (w_illegal_q),
        .rs1       (w_rs1),
        .rs2       (w_rs2),
        .rd        (w_rd)
    );

    // This no-ack cycle would be the MEM_TIMEOUT-th one spent waiting.
    assign w_timeout = !mem_ack && (r_wait_cnt == c_wait_last);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FETCH:  w_state_nxt = ST_FWAIT;
            ST_FWAIT: begin
                if (mem_ack) begin
                    w_state_nxt = ST_INCB;
                end else if (w_timeout) begin
                    w_state_nxt = ST_ERROR;
                end
            end
            ST_INCB:   w_state_nxt = ST_INC;
            ST_INC:    w_state_nxt = ST_DECODE;
            ST_DECODE: w_state_nxt = w_illegal_q ? ST_ERROR : ST_RS1R;
            ST_RS1R:   w_state_nxt = ST_RS1L;
            ST_RS1L:   w_state_nxt = w_is_addi ? ST_IMM : ST_RS2R;
            ST_RS2R:   w_state_nxt = ST_RS2L;
            ST_RS2L:   w_state_nxt = ST_EXEC;
            ST_IMM:    w_state_nxt = ST_EXEC;
            ST_EXEC:   w_state_nxt = ST_FETCH;
            ST_ERROR:  w_state_nxt = ST_ERROR;
            default:   w_state_nxt = ST_FETCH;
        endcase
    end

    // ------------------------------------------ wait counter, flags, instret
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt   <= '0;
            r_carry_flag <= 1'b0;
            r_instret    <= '0;
            r_illegal    <= 1'b0;
            r_mem_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: r_wait_cnt <= '0;
                ST_FWAIT: begin
                    if (!mem_ack) begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                    if (w_timeout) begin
                        r_mem_err <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    if (w_illegal_q) begin
                        r_illegal <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    r_carry_flag <= alu_carry;
                    r_instret    <= r_instret + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign carry_flag = r_carry_flag;
    assign instret    = r_instret;
    assign illegal    = r_illegal;
    assign mem_err    = r_mem_err;

    // -------------------------------------------------------------- outputs
    always_comb begin
        mem_req       = 1'b0;
        sel_alu_func  = ALU_ADD;
        ir_en         = 1'b0;
        a_en          = 1'b0;
        b_en          = 1'b0;
        pc_en         = 1'b0;
        immgen_bus_en = 1'b0;
        alu_bus_en    = 1'b0;
        pc_bus_en     = 1'b0;
        rf_bus_en     = 1'b0;
        rd_bus_en     = 1'b0;
        const4_bus_en = 1'b0;
        rf_wen        = 1'b0;
        rf_ren        = 1'b0;
        rf_addr_sel   = 5'd0;
        // Strobes stay quiet while reset is held so the datapath sees no
        // spurious loads during the reset window.
        if (!rst) begin
            case (r_state)
                ST_FETCH: begin
                    pc_bus_en = 1'b1;
                    mem_req   = 1'b1;
                    a_en      = 1'b1;
                end
                ST_FWAIT: begin
                    mem_req = 1'b1;
                    // Read data takes the bus in the ack cycle, so the PC
                    // driver steps aside to keep a single bus owner.
                    if (mem_ack) begin
                        rd_bus_en = 1'b1;
                        ir_en     = 1'b1;
                    end else begin
                        pc_bus_en = 1'b1;
                    end
                end
                ST_INCB: begin
                    const4_bus_en = 1'b1;
                    b_en          = 1'b1;
                end
                ST_INC: begin
                    alu_bus_en   = 1'b1;
                    sel_alu_func = ALU_ADD;
                    pc_en        = 1'b1;
                end
                ST_RS1R: begin
                    rf_ren      = 1'b1;
                    rf_addr_sel = w_rs1;
                end
                ST_RS1L: begin
                    rf_ren      = 1'b1;
                    rf_addr_sel = w_rs1;
                    rf_bus_en   = 1'b1;
                    a_en        = 1'b1;
                end
                ST_RS2R: begin
                    rf_ren      = 1'b1;
                    rf_addr_sel = w_rs2;
                end
                ST_RS2L: begin
                    rf_ren      = 1'b1;
                    rf_addr_sel = w_rs2;
                    rf_bus_en   = 1'b1;
                    b_en        = 1'b1;
                end
                ST_IMM: begin
                    immgen_bus_en = 1'b1;
                    b_en          = 1'b1;
                end
                ST_EXEC: begin
                    alu_bus_en   = 1'b1;
                    sel_alu_func = w_is_sub ? ALU_SUB : ALU_ADD;
                    rf_addr_sel  = w_rd;
                    // x0 is hardwired: the write is dropped, retirement is not.
                    rf_wen       = (w_rd != 5'd0);
                end
                default: ;
            endcase
        end
    end

    // Only the register-register forms are distinguished from ADDI above;
    // ADD itself needs no dedicated strobe beyond not being SUB.
    logic w_unused_is_add;
    assign w_unused_is_add = w_is_add;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctrl_fsm
// Description : Self-checking bench for ctrl_fsm. Directed vector table plus
//               random instructions compared against a per-instruction
//               behavioural model (latency, strobe counts, flags, counter).
//               A second instance with a 3-bit counter exposes the wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_fsm;

    localparam int RF_ADDR_W   = 4;
    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 32;
    localparam int SMALL_W     = 3;
    localparam int NO_ACK      = 1000;
    localparam int RUN_BOUND   = 48;

    logic clk = 1'b0;
    logic rst;
    logic [31:0] instr;
    logic alu_carry;
    logic mem_ack;

    logic mem_req, sel_alu_func, ir_en, a_en, b_en, pc_en;
    logic immgen_bus_en, alu_bus_en, pc_bus_en, rf_bus_en, rd_bus_en, const4_bus_en;
    logic rf_wen, rf_ren, carry_flag, illegal, mem_err;
    logic [4:0] rf_addr_sel;
    logic [CNT_W-1:0] instret;

    logic s_mem_req, s_sel_alu_func, s_ir_en, s_a_en, s_b_en, s_pc_en;
    logic s_immgen_bus_en, s_alu_bus_en, s_pc_bus_en, s_rf_bus_en, s_rd_bus_en, s_const4_bus_en;
    logic s_rf_wen, s_rf_ren, s_carry_flag, s_illegal, s_mem_err;
    logic [4:0] s_rf_addr_sel;
    logic [SMALL_W-1:0] s_instret;

    always #5 clk = ~clk;

    ctrl_fsm #(.RF_ADDR_W(RF_ADDR_W), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .instr(instr), .alu_carry(alu_carry), .mem_ack(mem_ack),
        .mem_req(mem_req), .sel_alu_func(sel_alu_func), .ir_en(ir_en), .a_en(a_en),
        .b_en(b_en), .pc_en(pc_en), .immgen_bus_en(immgen_bus_en), .alu_bus_en(alu_bus_en),
        .pc_bus_en(pc_bus_en), .rf_bus_en(rf_bus_en), .rd_bus_en(rd_bus_en),
        .const4_bus_en(const4_bus_en), .rf_wen(rf_wen), .rf_ren(rf_ren),
        .rf_addr_sel(rf_addr_sel), .carry_flag(carry_flag), .instret(instret),
        .illegal(illegal), .mem_err(mem_err)
    );

    ctrl_fsm #(.RF_ADDR_W(RF_ADDR_W), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(SMALL_W)) dut_small (
        .clk(clk), .rst(rst), .instr(instr), .alu_carry(alu_carry), .mem_ack(mem_ack),
        .mem_req(s_mem_req), .sel_alu_func(s_sel_alu_func), .ir_en(s_ir_en), .a_en(s_a_en),
        .b_en(s_b_en), .pc_en(s_pc_en), .immgen_bus_en(s_immgen_bus_en),
        .alu_bus_en(s_alu_bus_en), .pc_bus_en(s_pc_bus_en), .rf_bus_en(s_rf_bus_en),
        .rd_bus_en(s_rd_bus_en), .const4_bus_en(s_const4_bus_en), .rf_wen(s_rf_wen),
        .rf_ren(s_rf_ren), .rf_addr_sel(s_rf_addr_sel), .carry_flag(s_carry_flag),
        .instret(s_instret), .illegal(s_illegal), .mem_err(s_mem_err)
    );

    wire [5:0]  w_bus   = {immgen_bus_en, alu_bus_en, pc_bus_en, rf_bus_en, rd_bus_en, const4_bus_en};
    wire [5:0]  w_s_bus = {s_immgen_bus_en, s_alu_bus_en, s_pc_bus_en, s_rf_bus_en, s_rd_bus_en, s_const4_bus_en};
    wire [18:0] w_strb  = {mem_req, sel_alu_func, ir_en, a_en, b_en, pc_en, w_bus, rf_wen, rf_ren, rf_addr_sel};
    wire [18:0] w_s_strb = {s_mem_req, s_sel_alu_func, s_ir_en, s_a_en, s_b_en, s_pc_en, w_s_bus,
                            s_rf_wen, s_rf_ren, s_rf_addr_sel};
    wire [2:0]  w_flags   = {carry_flag, illegal, mem_err};
    wire [2:0]  w_s_flags = {s_carry_flag, s_illegal, s_mem_err};

    typedef struct {
        logic [31:0] instr;
        int          waits;
        logic        carry;
        int          exp_len;     // cycles FETCH..EXEC, -1 = ends in ERROR
        logic        exp_rtype;
        logic        exp_wen;
        logic [4:0]  exp_rd;
        logic        exp_sub;
        logic        exp_illegal;
        logic        exp_mem_err;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    int unsigned retired = 0;

    int o_len, o_mreq, o_ir, o_rd, o_c4, o_pcen, o_rfbus, o_rfren, o_imm, o_wen, o_sub;
    int o_bad_onehot, o_diverge;
    logic [4:0] o_exec_addr, o_rs1_addr, o_rs2_addr;
    logic o_last_any;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] iw, input int waits, input logic cy,
                                input int len, input logic rtype, input logic wen,
                                input logic [4:0] rd, input logic sub, input logic ill,
                                input logic merr);
        vec_t v;
        v.instr = iw; v.waits = waits; v.carry = cy; v.exp_len = len; v.exp_rtype = rtype;
        v.exp_wen = wen; v.exp_rd = rd; v.exp_sub = sub; v.exp_illegal = ill; v.exp_mem_err = merr;
        return v;
    endfunction

    // Behavioural reference: what one instruction should do, from its fields.
    function automatic vec_t model(input logic [31:0] iw, input int waits, input logic cy);
        logic is_r, is_i, regs_ok, ok;
        int   depth;
        depth   = 1 << RF_ADDR_W;
        is_r    = (iw[6:0] == 7'b0110011) && (iw[14:12] == 3'b000) &&
                  (iw[31:25] == 7'b0000000 || iw[31:25] == 7'b0100000);
        is_i    = (iw[6:0] == 7'b0010011) && (iw[14:12] == 3'b000);
        regs_ok = (int'(iw[11:7]) < depth) && (int'(iw[19:15]) < depth) &&
                  (!is_r || int'(iw[24:20]) < depth);
        ok      = (is_r || is_i) && regs_ok;
        // fetch + ack, PC+4 (2), decode, rs1 (2), rs2 (2) or imm (1), exec
        return mk(iw, waits, cy, ok ? (9 + (is_r ? 1 : 0) + waits) : -1, is_r,
                  iw[11:7] != 5'd0, iw[11:7], is_r && iw[30], !ok, 1'b0);
    endfunction

    // Entered in the FETCH cycle, just after the falling edge.
    task automatic run_instr(input logic [31:0] iw, input int waits, input logic cy);
        instr = iw; alu_carry = cy;
        o_len = -1; o_mreq = 0; o_ir = 0; o_rd = 0; o_c4 = 0; o_pcen = 0; o_rfbus = 0;
        o_rfren = 0; o_imm = 0; o_wen = 0; o_sub = 0; o_bad_onehot = 0; o_diverge = 0;
        o_exec_addr = 5'd31; o_rs1_addr = 5'd31; o_rs2_addr = 5'd31; o_last_any = 1'b1;
        for (int k = 0; k < RUN_BOUND; k++) begin
            mem_ack = (k == waits + 1);
            #1;
            if (k > 0 && a_en && pc_bus_en && mem_req) begin
                o_len = k;
                break;
            end
            if (mem_req) o_mreq++;
            if (ir_en) o_ir++;
            if (rd_bus_en) o_rd++;
            if (const4_bus_en) o_c4++;
            if (pc_en) o_pcen++;
            if (rf_ren) o_rfren++;
            if (immgen_bus_en) o_imm++;
            if (rf_wen) o_wen++;
            if (sel_alu_func) o_sub++;
            if (rf_bus_en) begin
                if (o_rfbus == 0) o_rs1_addr = rf_addr_sel;
                else              o_rs2_addr = rf_addr_sel;
                o_rfbus++;
            end
            if (alu_bus_en && !pc_en) o_exec_addr = rf_addr_sel;
            if ($countones(w_bus) > 1 || $countones(w_s_bus) > 1) o_bad_onehot++;
            if (w_strb != w_s_strb || w_flags != w_s_flags) o_diverge++;
            o_last_any = |w_strb;
            @(negedge clk);
        end
        mem_ack = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1; mem_ack = 1'b0;
        #1;
        chk({tag, "_rst_strobes_quiet"}, w_strb, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0; retired = 0;
        #1;
        chk({tag, "_rst_fetch"}, (a_en && pc_bus_en && mem_req && !ir_en) ? 1 : 0, 1);
        chk({tag, "_rst_flags"}, {w_flags, w_s_flags}, 0);
        chk({tag, "_rst_instret"}, instret, 0);
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        run_instr(v.instr, v.waits, v.carry);
        chk({tag, "_len"}, o_len, v.exp_len);
        chk({tag, "_bus_onehot_violations"}, o_bad_onehot, 0);
        chk({tag, "_narrow_copy_diverge"}, o_diverge, 0);
        if (v.exp_len > 0) begin
            retired++;
            chk({tag, "_rf_wen_cycles"}, o_wen, v.exp_wen);
            chk({tag, "_exec_addr"}, o_exec_addr, v.exp_rd);
            chk({tag, "_sub_cycles"}, o_sub, v.exp_sub);
            chk({tag, "_rf_ren_cycles"}, o_rfren, v.exp_rtype ? 4 : 2);
            chk({tag, "_imm_cycles"}, o_imm, v.exp_rtype ? 0 : 1);
            chk({tag, "_rs1_addr"}, o_rs1_addr, v.instr[19:15]);
            if (v.exp_rtype) chk({tag, "_rs2_addr"}, o_rs2_addr, v.instr[24:20]);
            chk({tag, "_fetch_strobes"}, {o_ir, o_rd, o_c4, o_pcen}, {32'd1, 32'd1, 32'd1, 32'd1});
            chk({tag, "_mem_req_cycles"}, o_mreq, v.waits + 2);
            chk({tag, "_carry_flag"}, carry_flag, v.carry);
            chk({tag, "_instret"}, instret, retired);
            chk({tag, "_narrow_instret"}, s_instret, retired % (1 << SMALL_W));
            chk({tag, "_flags_clear"}, {illegal, mem_err}, 0);
        end else begin
            chk({tag, "_illegal"}, illegal, v.exp_illegal);
            chk({tag, "_mem_err"}, mem_err, v.exp_mem_err);
            chk({tag, "_mem_req_cycles"}, o_mreq, v.exp_mem_err ? MEM_TIMEOUT + 1 : v.waits + 2);
            chk({tag, "_error_strobes"}, o_last_any, 0);
            chk({tag, "_instret_held"}, instret, retired);
            do_reset(tag);
        end
    endtask

    vec_t tbl [13];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; instr = 32'h0; alu_carry = 1'b0; mem_ack = 1'b0;

        tbl[0]  = mk(32'h00500093, 0,      1'b0,  9, 1'b0, 1'b1, 5'd1,  1'b0, 1'b0, 1'b0);
        tbl[1]  = mk(32'h402081B3, 3,      1'b1, 13, 1'b1, 1'b1, 5'd3,  1'b1, 1'b0, 1'b0);
        tbl[2]  = mk(32'h00208033, 0,      1'b0, 10, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0);
        tbl[3]  = mk(32'h007302B3, 2,      1'b1, 12, 1'b1, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0);
        tbl[4]  = mk(32'hFFF78793, 1,      1'b0, 10, 1'b0, 1'b1, 5'd15, 1'b0, 1'b0, 1'b0);
        tbl[5]  = mk(32'h01F18113, 0,      1'b1,  9, 1'b0, 1'b1, 5'd2,  1'b0, 1'b0, 1'b0);
        tbl[6]  = mk(32'h00000013, 4,      1'b0, 13, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0);
        tbl[7]  = mk(32'h00500093, 15,     1'b1, 24, 1'b0, 1'b1, 5'd1,  1'b0, 1'b0, 1'b0);
        tbl[8]  = mk(32'h00000073, 0,      1'b0, -1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0);
        tbl[9]  = mk(32'h00208833, 0,      1'b0, -1, 1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0);
        tbl[10] = mk(32'h414100B3, 1,      1'b0, -1, 1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0);
        tbl[11] = mk(32'h02208033, 0,      1'b0, -1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0);
        tbl[12] = mk(32'h00500093, NO_ACK, 1'b0, -1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1);

        @(negedge clk);
        do_reset("init");

        for (int i = 0; i < 13; i++) begin
            apply_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of a fetch wait returns straight to FETCH.
        instr = 32'h00500093; mem_ack = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("midwait_in_fwait", (mem_req && pc_bus_en && !a_en) ? 1 : 0, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; retired = 0;
        #1;
        chk("midwait_rst_fetch", (a_en && pc_bus_en && mem_req && !rd_bus_en) ? 1 : 0, 1);
        chk("midwait_rst_flags", {w_flags, instret}, 0);
        apply_vec(tbl[7], "after_midwait");

        // Counter wrap on the narrow instance after 2**SMALL_W retirements.
        do_reset("wrap");
        for (int i = 0; i < 7; i++) apply_vec(tbl[0], $sformatf("wrap%0d", i));
        chk("wrap_before", s_instret, 7);
        apply_vec(tbl[0], "wrap7");
        chk("wrap_to_zero", s_instret, 0);
        chk("wrap_wide_count", instret, 8);

        // Random instruction mix against the model.
        for (int i = 0; i < 40; i++) begin
            int          kind;
            int          waits;
            logic        cy;
            logic [4:0]  rd, rs1, rs2;
            logic [31:0] iw;
            kind  = $urandom_range(0, 9);
            waits = $urandom_range(0, 4);
            cy    = 1'($urandom_range(0, 1));
            rd    = 5'($urandom_range(0, 17));
            rs1   = 5'($urandom_range(0, 17));
            rs2   = 5'($urandom_range(0, 17));
            if (kind <= 3)      iw = {12'($urandom), rs1, 3'b000, rd, 7'b0010011};
            else if (kind <= 6) iw = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
            else if (kind <= 8) iw = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
            else                iw = $urandom;
            apply_vec(model(iw, waits, cy), $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
